// File: rtl/dino_pkg.sv
// Shared types and default timing for the dinosaur player-motion logic.
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        HOLD   = 2'd2,
        FALL   = 2'd3
    } jump_state_e;

    localparam int DEF_DIV         = 4;
    localparam int DEF_ANIM_TICKS  = 2_500_000;
    localparam int DEF_STEP_TICKS  = 62_500;
    localparam int DEF_JUMP_HEIGHT = 100;
    localparam int DEF_HOLD_STEPS  = 8;
    localparam int JADDR_W         = 7;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dino_jump_fsm.sv
// Jump controller: rise one row per step to the apex, hold, then fall back.
module dino_jump_fsm
    import dino_pkg::*;
#(
    parameter int STEP_TICKS  = DEF_STEP_TICKS,
    parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int HOLD_STEPS  = DEF_HOLD_STEPS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               button,
    input  logic               halt,
    output logic [JADDR_W-1:0] jumpaddr,
    output logic               airborne
);

    localparam int STEP_W = cnt_width(STEP_TICKS);
    localparam int HOLD_W = cnt_width(HOLD_STEPS);

    jump_state_e         state_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [JADDR_W-1:0]  jaddr_q;
    logic                airborne_q;
    logic                step_tick;

    assign step_tick = (step_cnt_q == STEP_W'(STEP_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= GROUND;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            jaddr_q    <= '0;
            airborne_q <= 1'b0;
        end else if (pix_en && !halt) begin
            // Step counter only runs while airborne; launch restarts it below.
            if (state_q != GROUND) begin
                step_cnt_q <= step_tick ? '0 : step_cnt_q + STEP_W'(1);
            end
            case (state_q)
                GROUND: begin
                    jaddr_q <= '0;
                    if (button) begin
                        state_q    <= RISE;
                        airborne_q <= 1'b1;
                        step_cnt_q <= '0;
                        hold_cnt_q <= '0;
                    end
                end
                RISE: begin
                    if (step_tick) begin
                        jaddr_q <= jaddr_q + JADDR_W'(1);
                        if (jaddr_q == JADDR_W'(JUMP_HEIGHT - 1)) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (step_tick) begin
                        if (hold_cnt_q == HOLD_W'(HOLD_STEPS - 1)) begin
                            state_q    <= FALL;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                    end
                end
                FALL: begin
                    if (step_tick && jaddr_q != '0) begin
                        jaddr_q <= jaddr_q - JADDR_W'(1);
                        if (jaddr_q == JADDR_W'(1)) begin
                            state_q    <= GROUND;
                            airborne_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= GROUND;
                    airborne_q <= 1'b0;
                end
            endcase
        end
    end

    assign jumpaddr = jaddr_q;
    assign airborne = airborne_q;

endmodule

// File: rtl/dino_player_ctrl.sv
// Player-motion control: pixel-rate divider, running-frame toggler and jump controller.
module dino_player_ctrl
    import dino_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int ANIM_TICKS  = DEF_ANIM_TICKS,
    parameter int STEP_TICKS  = DEF_STEP_TICKS,
    parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int HOLD_STEPS  = DEF_HOLD_STEPS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               button,
    input  logic               halt,
    output logic               divided_clk,
    output logic               pix_en,
    output logic               sprite,
    output logic [JADDR_W-1:0] jumpaddr,
    output logic               airborne
);

    localparam int DIV_W  = $clog2(DIV);
    localparam int ANIM_W = cnt_width(ANIM_TICKS);

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              divided_clk_q, divided_clk_d;
    logic              pix_en_q, pix_en_d;
    logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
    logic              sprite_q, sprite_d;

    // Outputs are registered copies of the counter's next value, so they
    // line up with div_cnt_q itself rather than lagging a cycle.
    always_comb begin
        div_cnt_d     = div_cnt_q + DIV_W'(1);
        divided_clk_d = div_cnt_d[DIV_W-1];
        pix_en_d      = (div_cnt_d == DIV_W'(DIV - 1));
        anim_cnt_d    = anim_cnt_q;
        sprite_d      = sprite_q;
        if (pix_en_q) begin
            if (anim_cnt_q == ANIM_W'(ANIM_TICKS - 1)) begin
                anim_cnt_d = '0;
                sprite_d   = ~sprite_q;
            end else begin
                anim_cnt_d = anim_cnt_q + ANIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            divided_clk_q <= 1'b0;
            pix_en_q      <= 1'b0;
            anim_cnt_q    <= '0;
            sprite_q      <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            divided_clk_q <= divided_clk_d;
            pix_en_q      <= pix_en_d;
            anim_cnt_q    <= anim_cnt_d;
            sprite_q      <= sprite_d;
        end
    end

    dino_jump_fsm #(
        .STEP_TICKS  (STEP_TICKS),
        .JUMP_HEIGHT (JUMP_HEIGHT),
        .HOLD_STEPS  (HOLD_STEPS)
    ) u_jump (
        .clk      (clk),
        .reset    (reset),
        .pix_en   (pix_en_q),
        .button   (button),
        .halt     (halt),
        .jumpaddr (jumpaddr),
        .airborne (airborne)
    );

    assign divided_clk = divided_clk_q;
    assign pix_en      = pix_en_q;
    assign sprite      = sprite_q;

endmodule

// File: tb/tb_dino_player_ctrl.sv
// Scoreboard bench for dino_player_ctrl with short timing constants.
module tb_dino_player_ctrl;
    import dino_pkg::*;

    localparam int DIV      = 4;
    localparam int ANIM     = 3;
    localparam int STEP     = 2;
    localparam int JH       = 4;
    localparam int HOLD     = 1;
    localparam int JUMP_LEN = (2 * JH + HOLD) * STEP;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               button = 1'b0;
    logic               halt = 1'b0;
    logic               divided_clk;
    logic               pix_en;
    logic               sprite;
    logic [JADDR_W-1:0] jumpaddr;
    logic               airborne;

    int n_checks = 0;
    int n_errors = 0;
    int ticks    = 0;
    int exp_addr_q[$];
    int exp_air_q[$];

    dino_player_ctrl #(
        .DIV         (DIV),
        .ANIM_TICKS  (ANIM),
        .STEP_TICKS  (STEP),
        .JUMP_HEIGHT (JH),
        .HOLD_STEPS  (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .halt        (halt),
        .divided_clk (divided_clk),
        .pix_en      (pix_en),
        .sprite      (sprite),
        .jumpaddr    (jumpaddr),
        .airborne    (airborne)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, ticks);
        end else begin
            $display("ok   %s = %0d (tick %0d)", tag, got, ticks);
        end
    endtask

    // Expected offset t pixel ticks after the launch tick (t=0).
    function automatic int jump_addr_at(input int t);
        if (t >= JUMP_LEN)            return 0;
        if (t < JH * STEP)            return t / STEP;
        if (t < (JH + HOLD + 1) * STEP) return JH;
        return JH - (t - (JH + HOLD) * STEP) / STEP;
    endfunction

    task automatic push_jump(input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            exp_addr_q.push_back(jump_addr_at(t));
            exp_air_q.push_back((t < JUMP_LEN) ? 1 : 0);
        end
    endtask

    // Advance to just after the next clk edge that consumes a pix_en pulse.
    task automatic tick();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * DIV && !seen; i++) begin
            seen = pix_en;
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            check_val("tick_timeout", 0, 1);
        end else begin
            ticks++;
            check_val("sprite", sprite, (ticks / ANIM) % 2);
        end
    endtask

    task automatic pop_check();
        check_val("jumpaddr", jumpaddr, exp_addr_q.pop_front());
        check_val("airborne", airborne, exp_air_q.pop_front());
    endtask

    task automatic drain();
        while (exp_addr_q.size() > 0) begin
            tick();
            pop_check();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_divided_clk", divided_clk, 0);
        check_val("rst_pix_en", pix_en, 0);
        check_val("rst_sprite", sprite, 0);
        check_val("rst_jumpaddr", jumpaddr, 0);
        check_val("rst_airborne", airborne, 0);
        reset = 1'b0;

        // Divider phase and sprite toggling at ticks 3 and 6.
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            check_val("divided_clk", divided_clk, ((k % DIV) >= DIV / 2) ? 1 : 0);
            check_val("pix_en", pix_en, ((k % DIV) == DIV - 1) ? 1 : 0);
            check_val("sprite_free", sprite, ((k / DIV) / ANIM) % 2);
        end
        ticks = 24 / DIV;

        // Single-tick button pulse: full jump then one idle ground tick.
        button = 1'b1;
        push_jump(0, JUMP_LEN + 1);
        tick();
        button = 1'b0;
        pop_check();
        drain();

        // Halt at jumpaddr=2 during RISE for 10 ticks.
        button = 1'b1;
        push_jump(0, 4);
        tick();
        button = 1'b0;
        pop_check();
        drain();
        halt = 1'b1;
        for (int i = 0; i < 10; i++) push_jump(4, 4);
        drain();
        halt = 1'b0;
        push_jump(5, JUMP_LEN);
        drain();

        // Halt has priority over a press on the ground.
        halt   = 1'b1;
        button = 1'b1;
        push_jump(JUMP_LEN + 1, JUMP_LEN + 2);
        drain();
        halt = 1'b0;

        // Held button: relaunch on the first ground tick after landing.
        push_jump(0, JUMP_LEN);
        push_jump(0, 6);
        drain();

        // Reset mid-jump with jumpaddr=3.
        check_val("pre_reset_jumpaddr", jumpaddr, 3);
        reset  = 1'b1;
        button = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid_rst_jumpaddr", jumpaddr, 0);
        check_val("mid_rst_airborne", airborne, 0);
        check_val("mid_rst_sprite", sprite, 0);
        check_val("mid_rst_divided_clk", divided_clk, 0);
        check_val("mid_rst_pix_en", pix_en, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dino_player_ctrl.md
# dino_player_ctrl

Player-motion control block for the dinosaur runner game. It derives the 25 MHz pixel-rate enable and clock from the 100 MHz board clock. It generates the two-frame running-animation select and the vertical jump offset added to the dinosaur sprite row address. It sits between the board clock/button inputs and the pixel-composition logic. Sub-functions: clock divider, dino sprite toggler, jump controller.

## Interface
Parameters:
- `DIV`, 4: board clocks per pixel tick (power of two, ≥2).
- `ANIM_TICKS`, 2_500_000: pixel ticks per running-frame toggle (0.1 s).
- `STEP_TICKS`, 62_500: pixel ticks per 1-row jump step (2.5 ms).
- `JUMP_HEIGHT`, 100: apex offset in rows (1..127).
- `HOLD_STEPS`, 8: step periods spent at apex.

Ports:
- `clk`  in  1  board clock, 100 MHz; the only clock.
- `reset`  in  1  synchronous, active-high.
- `button`  in  1  jump request, level, pre-synchronised.
- `halt`  in  1  collision freeze.
- `divided_clk`  out  1  clk/DIV, 50 % duty, registered.
- `pix_en`  out  1  one-`clk` pulse per DIV cycles; qualifies all internal state.
- `sprite`  out  1  running-frame select (1 = frame 1, 0 = frame 2).
- `jumpaddr`  out  7  upward sprite offset in rows; 0 = on ground.
- `airborne`  out  1  high whenever the jump FSM is not GROUND.

## Operation
- Divider: counter `div_cnt` of width log2(DIV) increments every `clk`. `divided_clk` = MSB of `div_cnt`. `pix_en` = 1 when `div_cnt` = DIV-1.
- Sprite toggler: counter over pix_en ticks. On the tick at which it reaches ANIM_TICKS-1, it wraps to 0 and `sprite` inverts. Free-running; not affected by `halt` (death frame selection is done downstream).
- Jump FSM, evaluated only on `pix_en`:
  - GROUND: `jumpaddr`=0. If `button`=1 and `halt`=0: go to RISE and clear the step counter.
  - RISE: on each step tick (step counter reaches STEP_TICKS-1, then wraps), `jumpaddr`+1. On the step where `jumpaddr` becomes JUMP_HEIGHT, go to HOLD.
  - HOLD: after HOLD_STEPS step ticks, go to FALL.
  - FALL: on each step tick, `jumpaddr`-1. On the step where it reaches 0, go to GROUND.
- `button` is ignored while airborne. If it is still held on the GROUND tick after landing, a new jump starts on that tick.
- `halt`=1: FSM state, step counter and `jumpaddr` are frozen. Halt has priority over a button press in GROUND.
- Arithmetic: `jumpaddr` never exceeds JUMP_HEIGHT and never underflows below 0. The step counter is sized for STEP_TICKS; the anim counter is sized for ANIM_TICKS.

## Timing
- Reset values, applied on the `clk` edge with `reset`=1 regardless of `pix_en`:
  - `div_cnt`=0, `divided_clk`=0, `pix_en`=0.
  - `sprite`=0, anim counter=0.
  - FSM=GROUND, `jumpaddr`=0, `airborne`=0, step counter=0.
- First `pix_en` occurs DIV cycles after reset release. `divided_clk` is low for DIV/2 cycles, then high for DIV/2.
- All outputs are registered; each updates on the `clk` edge on which `pix_en` is high.
- `airborne` rises on the same edge the FSM leaves GROUND.
- Reset mid-jump: `jumpaddr` reads 0 and `airborne` reads 0 on the very next edge.
- Full jump duration: (2·JUMP_HEIGHT + HOLD_STEPS)·STEP_TICKS pixel ticks.

## Structure
- Shared package `dino_pkg`:
  - jump-state enum (GROUND, RISE, HOLD, FALL);
  - default timing constants;
  - `JADDR_W`=7.
- Top `dino_player_ctrl` holds the divider and the sprite toggler.
- One sub-module `dino_jump_fsm` (clk, reset, pix_en, button, halt → jumpaddr, airborne).

## Test plan
Use DIV=4, ANIM_TICKS=3, STEP_TICKS=2, JUMP_HEIGHT=4, HOLD_STEPS=1.
- Reset for 3 cycles, then release:
  - `divided_clk` reads 0,0,1,1,0,… .
  - `pix_en` is high on cycles 4, 8, 12, … after release.
- Free-run: `sprite` toggles 0→1 on the 3rd pix_en tick and back to 0 on the 6th; `halt`=1 does not stop it.
- Pulse `button` for one pix_en tick:
  - `jumpaddr` steps 1,2,3,4 every 2 ticks;
  - holds 4 for 2 ticks;
  - then 3,2,1,0;
  - `airborne` falls with the return to GROUND.
  - Total 18 pix_en ticks.
- Assert `halt` while `jumpaddr`=2 in RISE for 10 ticks: value stays 2; after release, it reaches 3 two ticks later.
- Hold `button` continuously: a second jump starts on the first GROUND tick after landing; presses during FALL have no effect.
- Assert `reset` at `jumpaddr`=3: next edge `jumpaddr`=0, `airborne`=0, `sprite`=0, `divided_clk`=0.
